// File: rtl/clk_synth_if.sv
// Request/status bundle for clk_synth: frequency request handshake plus
// the generated clock and its status flags.
interface clk_synth_if #(
    parameter int FREQ_W = 26
);
    logic [FREQ_W-1:0] freq_set;
    logic              set_valid;
    logic              set_ready;
    logic              clk_out;
    logic              locked;
    logic              err;
    logic [25:0]       div_out;

    // Requester side (board logic or bench)
    modport master (
        output freq_set, set_valid,
        input  set_ready, clk_out, locked, err, div_out
    );

    // Generator side
    modport slave (
        input  freq_set, set_valid,
        output set_ready, clk_out, locked, err, div_out
    );
endinterface

// File: rtl/clk_synth.sv
// Programmable square-wave generator. A requested frequency is turned into
// a half-period divisor N = floor(CLK_FS / (2*freq)) by a 26-step restoring
// divider, then clk_out toggles every N reference cycles. A retune while
// running only swaps N on a toggle edge, so every half-period is either the
// old N or the new N.
module clk_synth #(
    parameter logic [25:0] CLK_FS = 26'd50_000_000,
    parameter int          FREQ_W = 26
) (
    input  logic        clk_fs,
    input  logic        rst_n,
    clk_synth_if.slave  bus
);
    localparam int DW = FREQ_W + 2;   // shifted partial remainder width

    typedef enum logic [1:0] {IDLE, DIV, APPLY, RUN} state_t;

    state_t            state;
    logic [FREQ_W-1:0] freq_q;
    logic [FREQ_W:0]   rem;
    logic [25:0]       quo;
    logic [4:0]        bidx;
    logic [25:0]       hcnt;
    logic [25:0]       div_q;
    logic              run_act;       // clock generator is toggling on div_q
    logic              clk_q;
    logic              ready_q;
    logic              locked_q;
    logic              err_q;

    // Divider datapath: bring down one dividend bit, subtract 2*freq if it fits
    logic [DW-1:0] d_ext;
    logic [DW-1:0] r_sh;
    logic [DW-1:0] r_nxt;
    logic          q_bit;
    logic          unused_rtop;

    assign d_ext       = {1'b0, freq_q, 1'b0};
    assign r_sh        = {rem, CLK_FS[bidx]};
    assign q_bit       = (r_sh >= d_ext);
    assign r_nxt       = q_bit ? (r_sh - d_ext) : r_sh;
    // remainder stays below 2*freq, so the top bit is always zero
    assign unused_rtop = r_nxt[DW-1];

    // Toggle event of the running generator: last count of the half-period
    logic tgl;
    assign tgl = run_act && (hcnt == div_q - 26'd1);

    // Control FSM, divider and half-period counter with registered outputs
    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            freq_q   <= '0;
            rem      <= '0;
            quo      <= '0;
            bidx     <= '0;
            hcnt     <= '0;
            div_q    <= '0;
            run_act  <= 1'b0;
            clk_q    <= 1'b0;
            ready_q  <= 1'b1;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // Generator keeps running on the current N through DIV/APPLY
            if (run_act) begin
                if (tgl) begin
                    clk_q <= ~clk_q;
                    hcnt  <= '0;
                end else begin
                    hcnt  <= hcnt + 26'd1;
                end
            end

            case (state)
                IDLE, RUN: begin
                    if (bus.set_valid) begin
                        freq_q   <= bus.freq_set;
                        err_q    <= 1'b0;
                        locked_q <= 1'b0;
                        ready_q  <= 1'b0;
                        rem      <= '0;
                        quo      <= '0;
                        bidx     <= 5'd25;
                        state    <= DIV;
                    end
                end

                DIV: begin
                    rem  <= r_nxt[FREQ_W:0];
                    quo  <= {quo[24:0], q_bit};
                    bidx <= bidx - 5'd1;
                    if (bidx == 5'd0)
                        state <= APPLY;
                end

                APPLY: begin
                    if (freq_q == '0 || quo == '0) begin
                        // unrealisable request: stop the output entirely
                        err_q   <= 1'b1;
                        clk_q   <= 1'b0;
                        hcnt    <= '0;
                        div_q   <= '0;
                        run_act <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else if (!run_act) begin
                        // stopped: start fresh, low phase first
                        div_q    <= quo;
                        clk_q    <= 1'b0;
                        hcnt     <= '0;
                        run_act  <= 1'b1;
                        locked_q <= 1'b1;
                        ready_q  <= 1'b1;
                        state    <= RUN;
                    end else if (tgl) begin
                        // running: swap N on this toggle so no runt half-period
                        div_q    <= quo;
                        locked_q <= 1'b1;
                        ready_q  <= 1'b1;
                        state    <= RUN;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.set_ready = ready_q;
    assign bus.clk_out   = clk_q;
    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.div_out   = div_q;
endmodule

// File: tb/tb_clk_synth.sv
// Directed bench for clk_synth: divisor values, waveform timing, glitch-free
// retune, error path, back-to-back requests and asynchronous reset.
module tb_clk_synth;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    clk_synth_if #(.FREQ_W(26)) bus ();

    clk_synth #(.CLK_FS(26'd50_000_000), .FREQ_W(26)) u_dut (
        .clk_fs (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one-cycle request pulse; returns just after the accept edge
    task automatic req(input logic [25:0] f);
        bus.freq_set  = f;
        bus.set_valid = 1'b1;
        tick(1);
        bus.set_valid = 1'b0;
    endtask

    task automatic wait_lock(input string tag);
        int c;
        c = 0;
        while (bus.locked !== 1'b1 && c < 400) begin
            tick(1);
            c++;
        end
        chk(tag, {31'd0, bus.locked}, 32'd1);
    endtask

    // length in cycles of the next complete half-period (-1 on timeout)
    task automatic half(output int n);
        logic p;
        int   c;
        n = -1;
        p = bus.clk_out;
        c = 0;
        while (bus.clk_out === p && c < 400) begin tick(1); c++; end
        p = bus.clk_out;
        c = 0;
        while (bus.clk_out === p && c < 400) begin tick(1); c++; end
        if (bus.clk_out !== p) n = c;
    endtask

    initial begin : main
        int h;
        int hi_seen;
        bus.freq_set  = '0;
        bus.set_valid = 1'b0;

        // reset values
        tick(3);
        chk("rst_ready",  {31'd0, bus.set_ready}, 32'd1);
        chk("rst_clk",    {31'd0, bus.clk_out},   32'd0);
        chk("rst_locked", {31'd0, bus.locked},    32'd0);
        chk("rst_err",    {31'd0, bus.err},       32'd0);
        chk("rst_div",    {6'd0, bus.div_out},    32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1 MHz from IDLE: ready low 27 cycles, N=25, 25 high / 25 low
        req(26'd1_000_000);
        chk("m1_ready_lo0", {31'd0, bus.set_ready}, 32'd0);
        tick(26);
        chk("m1_ready_lo26", {31'd0, bus.set_ready}, 32'd0);
        tick(1);  // load edge E0
        chk("m1_ready", {31'd0, bus.set_ready}, 32'd1);
        chk("m1_locked", {31'd0, bus.locked}, 32'd1);
        chk("m1_div", {6'd0, bus.div_out}, 32'd25);
        chk("m1_clk0", {31'd0, bus.clk_out}, 32'd0);
        tick(24);
        chk("m1_lo_end", {31'd0, bus.clk_out}, 32'd0);
        tick(1);  // E0+25
        chk("m1_rise", {31'd0, bus.clk_out}, 32'd1);
        tick(24);
        chk("m1_hi_end", {31'd0, bus.clk_out}, 32'd1);
        tick(1);  // E0+50
        chk("m1_fall", {31'd0, bus.clk_out}, 32'd0);

        // retune to 500 kHz while running: accept E0+51, APPLY ends E0+78,
        // next old toggles at E0+75 (rise) and E0+100 (load, fall)
        req(26'd500_000);
        chk("rt_unlock", {31'd0, bus.locked}, 32'd0);
        tick(23);  // E0+74
        chk("rt_old_lo", {31'd0, bus.clk_out}, 32'd0);
        tick(1);   // E0+75
        chk("rt_old_rise", {31'd0, bus.clk_out}, 32'd1);
        tick(24);  // E0+99
        chk("rt_old_hi", {31'd0, bus.clk_out}, 32'd1);
        chk("rt_pend_div", {6'd0, bus.div_out}, 32'd25);
        chk("rt_pend_lock", {31'd0, bus.locked}, 32'd0);
        tick(1);   // E0+100
        chk("rt_sw_fall", {31'd0, bus.clk_out}, 32'd0);
        chk("rt_sw_lock", {31'd0, bus.locked}, 32'd1);
        chk("rt_sw_div", {6'd0, bus.div_out}, 32'd50);
        tick(49);
        chk("rt_new_lo", {31'd0, bus.clk_out}, 32'd0);
        tick(1);   // E0+150
        chk("rt_new_rise", {31'd0, bus.clk_out}, 32'd1);

        // 7 MHz: N=3, 6-cycle period
        req(26'd7_000_000);
        wait_lock("m7_lock");
        chk("m7_div", {6'd0, bus.div_out}, 32'd3);
        half(h);
        chk("m7_half_a", h, 32'd3);
        half(h);
        chk("m7_half_b", h, 32'd3);

        // 25 MHz: N=1, toggles every cycle
        req(26'd25_000_000);
        wait_lock("m25_lock");
        chk("m25_div", {6'd0, bus.div_out}, 32'd1);
        half(h);
        chk("m25_half", h, 32'd1);

        // 3 Hz: N=8_333_333
        req(26'd3);
        wait_lock("m3_lock");
        chk("m3_div", {6'd0, bus.div_out}, 32'd8_333_333);

        // freq 0 -> error at end of cycle 27
        req(26'd0);
        tick(26);
        chk("z_err_pre", {31'd0, bus.err}, 32'd0);
        tick(1);
        chk("z_err", {31'd0, bus.err}, 32'd1);
        chk("z_clk", {31'd0, bus.clk_out}, 32'd0);
        chk("z_locked", {31'd0, bus.locked}, 32'd0);
        chk("z_div", {6'd0, bus.div_out}, 32'd0);
        chk("z_ready", {31'd0, bus.set_ready}, 32'd1);

        // 30 MHz -> N=0 error; accept clears the sticky err first
        req(26'd30_000_000);
        chk("h_err_clr", {31'd0, bus.err}, 32'd0);
        tick(27);
        chk("h_err", {31'd0, bus.err}, 32'd1);
        chk("h_clk", {31'd0, bus.clk_out}, 32'd0);
        chk("h_div", {6'd0, bus.div_out}, 32'd0);

        // valid request clears err and runs again
        req(26'd1_000_000);
        chk("r_err_clr", {31'd0, bus.err}, 32'd0);
        tick(27);
        chk("r_locked", {31'd0, bus.locked}, 32'd1);
        chk("r_div", {6'd0, bus.div_out}, 32'd25);
        chk("r_err", {31'd0, bus.err}, 32'd0);

        // reset mid-DIV while running
        req(26'd500_000);
        tick(9);
        rst_n = 1'b0;
        #1;
        chk("ar_clk", {31'd0, bus.clk_out}, 32'd0);
        chk("ar_locked", {31'd0, bus.locked}, 32'd0);
        chk("ar_div", {6'd0, bus.div_out}, 32'd0);
        chk("ar_ready", {31'd0, bus.set_ready}, 32'd1);
        tick(2);
        rst_n = 1'b1;
        hi_seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (bus.clk_out !== 1'b0 || bus.locked !== 1'b0) hi_seen++;
        end
        chk("ar_quiet", hi_seen, 32'd0);
        chk("ar_div_q", {6'd0, bus.div_out}, 32'd0);

        // set_valid held high: re-accepted the cycle after ready returns
        bus.freq_set  = 26'd25_000_000;
        bus.set_valid = 1'b1;
        tick(1);
        tick(26);
        chk("bb_ready_lo", {31'd0, bus.set_ready}, 32'd0);
        tick(1);
        chk("bb_ready", {31'd0, bus.set_ready}, 32'd1);
        chk("bb_locked", {31'd0, bus.locked}, 32'd1);
        tick(1);
        chk("bb_reacc_ready", {31'd0, bus.set_ready}, 32'd0);
        chk("bb_reacc_lock", {31'd0, bus.locked}, 32'd0);
        bus.set_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
